// File: rtl/gcd_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gcd_req_ctrl
// Brief    : Requester for a GCD engine. Queues operand pairs in a small FIFO,
//            issues each pair with a one-cycle start pulse, waits for done
//            (with watchdog), and returns {a, b, c, err} over valid/ready.
// Options  : GCD_ZERO_BYPASS_EN - pairs with a zero operand skip the engine
//            and return a|b directly.
// Revision : 1.0 - initial release
// ============================================================================
module gcd_req_ctrl #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic [WIDTH-1:0]         gcd_a,
  output logic [WIDTH-1:0]         gcd_b,
  output logic                     gcd_start,
  input  logic                     gcd_done,
  input  logic [WIDTH-1:0]         gcd_c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [WIDTH-1:0]         out_c,
  output logic                     out_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  // Last timer value before the watchdog fires; the timer starts at 0 on WAIT entry.
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [WIDTH-1:0]     gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
  logic [WIDTH-1:0]     out_a_q, out_a_d, out_b_q, out_b_d, out_c_q, out_c_d;
  logic                 out_err_q, out_err_d, out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0]   mem_q [DEPTH];
  logic                 push, pop;
  logic [WIDTH-1:0]     head_a, head_b;

  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head_a   = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
  assign head_b   = mem_q[rd_ptr_q][WIDTH-1:0];

  // FIFO storage: data needs no reset, emptiness is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  // Next-state, FIFO bookkeeping and output register updates.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    gcd_a_d     = gcd_a_q;
    gcd_b_d     = gcd_b_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_c_d     = out_c_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          gcd_a_d = head_a;
          gcd_b_d = head_b;
          out_a_d = head_a;
          out_b_d = head_b;
`ifdef GCD_ZERO_BYPASS_EN
          if ((head_a == '0) || (head_b == '0)) begin
            out_c_d     = head_a | head_b;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ISSUE;
          end
`else
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the watchdog's last cycle still wins.
        if (gcd_done) begin
          out_c_d     = gcd_c;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (timer_q == TMAX) begin
          out_c_d     = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_c_q     <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      gcd_a_q     <= gcd_a_d;
      gcd_b_q     <= gcd_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_c_q     <= out_c_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gcd_start = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign gcd_a     = gcd_a_q;
  assign gcd_b     = gcd_b_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_c     = out_c_q;
  assign out_err   = out_err_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gcd_req_ctrl
// Brief    : Scoreboard bench for gcd_req_ctrl with a behavioural GCD engine
//            (done three cycles after start). Honours GCD_ZERO_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_req_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic [WIDTH-1:0] gcd_a, gcd_b, gcd_c;
  logic             gcd_start, gcd_done;
  logic             out_valid, out_ready = 1'b1;
  logic [WIDTH-1:0] out_a, out_b, out_c;
  logic             out_err, busy;
  logic [$clog2(DEPTH):0] count;

  int   n_vec = 0, n_bad = 0;
  int   cyc = 0, start_cnt = 0, start_cyc = 0, rise_cyc = 0, peak = 0;
  logic prev_ov = 1'b0;
  exp_t sb[$];

  // Engine model state
  logic             eng_en = 1'b1, force_done = 1'b0;
  logic [2:0]       eng_cnt = '0;
  logic [WIDTH-1:0] ea = '0, eb = '0;

  gcd_req_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_start(gcd_start), .gcd_done(gcd_done), .gcd_c(gcd_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_c(out_c), .out_err(out_err), .busy(busy),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, t;
    x = a; y = b;
    while (y != '0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Engine: latches operands on start, asserts done three cycles later.
  // It deliberately ignores rst_n so a late done can reach the DUT after reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gcd_start) start_cnt <= start_cnt + 1;
    if (gcd_start && eng_en) begin
      eng_cnt <= 3'd3; ea <= gcd_a; eb <= gcd_b;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 3'd1;
    end
  end
  assign gcd_done = (eng_cnt == 3'd1) || force_done;
  assign gcd_c    = gcd_ref(ea, eb);

  // Output monitor: compares each handshake against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (count > peak) peak = count;
    if (gcd_start) start_cyc = cyc;
    if (out_valid && !prev_ov) rise_cyc = cyc;
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_a", 32'(out_a), 32'(e.a));
        chk("out_b", 32'(out_b), 32'(e.b));
        chk("out_c", 32'(out_c), 32'(e.c));
        chk("out_err", 32'(out_err), 32'(e.err));
      end
    end
  end

  // Offer one pair, wait (bounded) for acceptance; in_valid stays high afterwards.
  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic err);
    int g;
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    g = 0;
    while (!in_ready && g < 200) begin
      @(negedge clk); g++;
    end
    if (!in_ready) chk("push_timeout", 32'd1, 32'd0);
    @(posedge clk);
    e.a = a; e.b = b; e.c = err ? '0 : gcd_ref(a, b); e.err = err;
    sb.push_back(e);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int g;
    g = 0;
    while (!(sb.size() == 0 && !busy && count == 0) && g < budget) begin
      @(negedge clk); g++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int s0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_start", 32'(gcd_start), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single pair, latency and one start pulse
    s0 = start_cnt;
    push(8'd4, 8'd8, 1'b0);
    idle_in();
    chk("t1_count_after_push", 32'(count), 32'd1);
    chk("t1_start_not_yet", 32'(gcd_start), 32'd0);
    @(negedge clk);
    chk("t1_start_n2", 32'(gcd_start), 32'd1);
    chk("t1_gcd_a", 32'(gcd_a), 32'd4);
    chk("t1_gcd_b", 32'(gcd_b), 32'd8);
    drain(100);
    chk("t1_starts", 32'(start_cnt - s0), 32'd1);

    // 2: three back-to-back pairs
    s0 = start_cnt; peak = 0;
    push(8'd3, 8'd2, 1'b0);
    push(8'd6, 8'd14, 1'b0);
    push(8'd7, 8'd14, 1'b0);
    idle_in();
    drain(200);
    chk("t2_starts", 32'(start_cnt - s0), 32'd3);
    chk("t2_peak", 32'(peak), 32'd2);
    chk("t2_count_end", 32'(count), 32'd0);

    // 3: backpressure, FIFO fills, no new issue while holding
    s0 = start_cnt;
    out_ready = 1'b0;
    push(8'd12, 8'd18, 1'b0);
    push(8'd9, 8'd27, 1'b0);
    push(8'd35, 8'd21, 1'b0);
    push(8'd17, 8'd5, 1'b0);
    push(8'd100, 8'd75, 1'b0);
    idle_in();
    chk("t3_count_full", 32'(count), 32'(DEPTH));
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    repeat (20) @(negedge clk);
    chk("t3_one_start_in_hold", 32'(start_cnt - s0), 32'd1);
    chk("t3_holding_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    drain(300);
    chk("t3_starts", 32'(start_cnt - s0), 32'd5);

    // 4: watchdog timeout then recovery
    eng_en = 1'b0;
    push(8'd9, 8'd6, 1'b1);
    idle_in();
    drain(100);
    chk("t4_timeout_latency", 32'(rise_cyc - start_cyc), 32'(TIMEOUT + 1));
    eng_en = 1'b1;
    push(8'd12, 8'd20, 1'b0);
    idle_in();
    drain(100);

    // 5: reset in WAIT with two pairs queued, late done ignored
    eng_en = 1'b0;
    push(8'd5, 8'd10, 1'b0);
    push(8'd7, 8'd21, 1'b0);
    push(8'd8, 8'd12, 1'b0);
    idle_in();
    repeat (3) @(negedge clk);
    chk("t5_count_queued", 32'(count), 32'd2);
    chk("t5_busy_wait", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_start", 32'(gcd_start), 32'd0);
    chk("t5_rst_gcd_a", 32'(gcd_a), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_late_done_valid", 32'(out_valid), 32'd0);
    chk("t5_late_done_busy", 32'(busy), 32'd0);
    eng_en = 1'b1;

    // 6: zero operand
    s0 = start_cnt;
    push(8'd0, 8'd14, 1'b0);
    idle_in();
    drain(100);
`ifdef GCD_ZERO_BYPASS_EN
    chk("t6_starts", 32'(start_cnt - s0), 32'd0);
`else
    chk("t6_starts", 32'(start_cnt - s0), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gcd_req_ctrl.md
Name: gcd_req_ctrl

Overview:
Requester side of the GCD engine's start/operand/result interface. It queues incoming operand pairs, issues each pair to a downstream gcd engine with a one-cycle start pulse, waits for the engine's done, and returns the result with its operands over a valid/ready output. A watchdog flags engines that never complete. Sits between the operand source (host/sequencer) and the gcd compute unit.

Parameters:
WIDTH, 8, operand and result width
DEPTH, 4, operand FIFO entries (power of 2, >=2)
TIMEOUT, 255, max cycles in WAIT before error (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair offered
in_ready  out  1  FIFO can accept (count < DEPTH)
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
gcd_a  out  WIDTH  operand a to engine
gcd_b  out  WIDTH  operand b to engine
gcd_start  out  1  one-cycle start pulse to engine
gcd_done  in  1  engine result valid (single-cycle pulse)
gcd_c  in  WIDTH  engine result
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_a  out  WIDTH  operand a of returned result
out_b  out  WIDTH  operand b of returned result
out_c  out  WIDTH  gcd result
out_err  out  1  1 = timeout, out_c forced 0
busy  out  1  FSM not IDLE
count  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, count=0, in_ready=1, FSM=IDLE, all other outputs 0; gcd_start drops immediately, no completion of in-flight op.
- FIFO: push on in_valid&&in_ready; in_ready depends only on count (no full-bypass). Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- FSM states IDLE, ISSUE, WAIT, HOLD.
- IDLE: FIFO non-empty -> pop head, register gcd_a/gcd_b and out_a/out_b, go ISSUE.
- ISSUE: gcd_start=1 for exactly this cycle; timer cleared; -> WAIT.
- WAIT: timer increments each cycle. gcd_done=1 -> out_c<=gcd_c, out_err<=0, out_valid<=1, -> HOLD. Timer reaches TIMEOUT without done -> out_c<=0, out_err<=1, out_valid<=1, -> HOLD. Done and timeout in the same cycle: done wins.
- HOLD: out_valid, out_a/b/c and out_err held stable until out_ready=1. On handshake, out_valid<=0, -> IDLE.
- gcd_done ignored outside WAIT.
- gcd_a/gcd_b stable from ISSUE through HOLD.
- busy = (state != IDLE).
- Latency: push at edge N into empty FIFO, idle FSM -> pop at edge N+1, gcd_start high during cycle N+2. out_valid rises the edge after gcd_done is sampled.
- Minimum issue period: ISSUE + WAIT(>=1) + HOLD(>=1) + IDLE = 4 cycles.

Optional Feature:
GCD_ZERO_BYPASS_EN
- Defined: in IDLE, a popped pair with a==0 or b==0 skips ISSUE/WAIT. FSM goes straight to HOLD with out_c = a|b, out_err=0. gcd_start is never pulsed for that pair. Covers (0,0) -> 0.
- Undefined: every pair goes to the engine.

Test Plan:
1. Engine model (done 3 cycles after start). Push (4,8) -> one gcd_start, out_c=4, out_err=0, out_a=4, out_b=8.
2. Push (3,2),(6,14),(7,14) back-to-back -> results 1,2,7 in order. Exactly one start per pair; count peaks at 2 then drains to 0.
3. out_ready held 0. Push DEPTH+1=5 pairs -> in_ready=0 at count=4. No second gcd_start while in HOLD. Release out_ready -> all 5 results returned in order.
4. TIMEOUT=16, engine never asserts done, push (9,6) -> out_valid with out_err=1, out_c=0 exactly 16 cycles after the WAIT entry. FSM recovers for the next pair.
5. rst_n pulsed low mid-WAIT with 2 queued pairs -> outputs 0, count=0, in_ready=1 immediately. Late gcd_done after reset is ignored.
6. With GCD_ZERO_BYPASS_EN: (0,14) -> out_c=14, no gcd_start. Without the macro: a gcd_start is pulsed and the engine's result is returned.
